// File: rtl/nes_pad_pkg.sv
// ----------------------------------------------------------------------------
// nes_pad_pkg
// Shared definitions for the NES joypad responder:
//   - PAD_BITS      : number of buttons on a standard pad
//   - btn_idx_e     : bit position of each button in the button vector
//   - pad_state_e   : responder state encoding (LOAD / SHIFT / DRAINED)
// ----------------------------------------------------------------------------
package nes_pad_pkg;

    localparam int PAD_BITS = 8;

    // Bit position of each button in the 8-bit button vector (1 = pressed).
    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_idx_e;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,  // filtered strobe high, snapshot tracks the buttons
        SHIFT   = 2'd1,  // strobe low, fewer than 8 shifts so far
        DRAINED = 2'd2   // strobe low, all 8 buttons shifted out
    } pad_state_e;

endpackage

// File: rtl/nes_pad_in_filter.sv
// ----------------------------------------------------------------------------
// nes_pad_in_filter
// Conditions one asynchronous console line: SYNC_STAGES-flop synchronizer,
// then a glitch filter that accepts a new level only after FILTER_CYCLES
// consecutive equal samples, then registered rise/fall pulse generation.
// Input-to-pulse latency is SYNC_STAGES + FILTER_CYCLES clocks.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   async_i  in   raw asynchronous input line
//   level_o  out  filtered level
//   rise_o   out  one-cycle pulse when the filtered level goes 0 -> 1
//   fall_o   out  one-cycle pulse when the filtered level goes 1 -> 0
// ----------------------------------------------------------------------------
module nes_pad_in_filter
    import nes_pad_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   level_q, level_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // NOTE: the synchronizer flops carry no reset; they keep sampling through
    // reset so the filter can adopt the true line level when reset is applied.
    always_ff @(posedge clock) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end

    assign sample = sync_q[SYNC_STAGES-1];

    // NOTE: every combinational output gets a default first so no latch is
    // inferred on the paths that do not assign it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample != level_q) begin
            if (cnt_q == 4'(FILTER_CYCLES - 1)) begin
                level_d = sample;
                rise_d  = sample;
                fall_d  = ~sample;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            // Adopt the current line level so reset release makes no edge.
            level_q <= sample;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/nes_pad_responder.sv
// ----------------------------------------------------------------------------
// nes_pad_responder
// Controller-side end of the NES joypad serial link, emulating the pad's
// 4021 parallel-in/serial-out register. While the filtered strobe is high the
// register follows the buttons; on its falling edge the snapshot is frozen and
// each accepted pad_clock edge shifts one button out on pad_data (active-low).
//
// Optional feature (macro NES_PAD_TURBO_EN): adds input turbo_en and parameter
// TURBO_DIV; A/B with turbo enabled alternate pressed/released every
// TURBO_DIV frames.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-high reset
//   turbo_en     in   [1:0] turbo enables for A/B (NES_PAD_TURBO_EN only)
//   buttons      in   [7:0] live buttons, 1 = pressed, [0]=A ... [7]=Right
//   pad_strobe   in   console latch line (asynchronous)
//   pad_clock    in   console shift clock (asynchronous)
//   pad_data     out  registered serial data, 0 = pressed
//   latch_pulse  out  one-cycle pulse on the accepted strobe falling edge
//   shift_count  out  [3:0] shifts since the last latch, saturating at 8
// ----------------------------------------------------------------------------
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int SHIFT_ON_RISE = 1,
    parameter int FILL_PRESSED  = 1
`ifdef NES_PAD_TURBO_EN
    , parameter int TURBO_DIV   = 4
`endif
) (
    input  logic                clock,
    input  logic                reset,
`ifdef NES_PAD_TURBO_EN
    input  logic [1:0]          turbo_en,
`endif
    input  logic [PAD_BITS-1:0] buttons,
    input  logic                pad_strobe,
    input  logic                pad_clock,
    output logic                pad_data,
    output logic                latch_pulse,
    output logic [3:0]          shift_count
);

    // Register bit shifted in behind the buttons (1 = reads as pressed).
    localparam logic FILL_BIT = (FILL_PRESSED != 0);

    logic str_level, str_rise, str_fall;
    logic clk_level, clk_rise, clk_fall;
    logic shift_edge;
    logic unused_ok;

    pad_state_e          state_q, state_d;
    logic [PAD_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]          count_q, count_d;
    logic                data_q, data_d;
    logic [PAD_BITS-1:0] load_val;

    nes_pad_in_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_strobe_filter (
        .clock   (clock),
        .reset   (reset),
        .async_i (pad_strobe),
        .level_o (str_level),
        .rise_o  (str_rise),
        .fall_o  (str_fall)
    );

    nes_pad_in_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_clock_filter (
        .clock   (clock),
        .reset   (reset),
        .async_i (pad_clock),
        .level_o (clk_level),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    // The strobe level alone decides LOAD (its rise coincides with the level
    // going high), and only one clock edge polarity is used for shifting.
    assign unused_ok  = ^{str_rise, clk_level};
    assign shift_edge = (SHIFT_ON_RISE != 0) ? clk_rise : clk_fall;

`ifdef NES_PAD_TURBO_EN
    localparam int TURBO_W = (2 * TURBO_DIV > 1) ? $clog2(2 * TURBO_DIV) : 1;

    logic [TURBO_W-1:0] turbo_cnt_q, turbo_cnt_d;
    logic               turbo_off;

    // Frames with counter >= TURBO_DIV report turbo buttons as released.
    assign turbo_off = (turbo_cnt_q >= TURBO_W'(TURBO_DIV));

    always_comb begin
        turbo_cnt_d = turbo_cnt_q;
        if (latch_pulse) begin
            if (turbo_cnt_q == TURBO_W'(2 * TURBO_DIV - 1)) begin
                turbo_cnt_d = '0;
            end else begin
                turbo_cnt_d = turbo_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        load_val = buttons;
        if (turbo_off) begin
            if (turbo_en[0]) load_val[BTN_A] = 1'b0;
            if (turbo_en[1]) load_val[BTN_B] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            turbo_cnt_q <= '0;
        end else begin
            turbo_cnt_q <= turbo_cnt_d;
        end
    end
`else
    assign load_val = buttons;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        data_d  = data_q;
        if (str_level) begin
            // Strobe high wins over any shift edge accepted this cycle.
            state_d = LOAD;
            shreg_d = load_val;
            count_d = 4'd0;
            data_d  = ~load_val[BTN_A];
        end else begin
            unique case (state_q)
                LOAD: begin
                    // Strobe just fell: the last loaded snapshot is kept.
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (shift_edge) begin
                        shreg_d = {FILL_BIT, shreg_q[PAD_BITS-1:1]};
                        count_d = count_q + 4'd1;
                        data_d  = ~shreg_q[1];
                        if (count_q == 4'd7) begin
                            state_d = DRAINED;
                        end
                    end
                end
                DRAINED: begin
                    data_d = ~FILL_BIT;
                end
                default: begin
                    state_d = SHIFT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SHIFT;
            shreg_q <= '0;
            count_q <= 4'd0;
            data_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign pad_data    = data_q;
    assign latch_pulse = str_fall;
    assign shift_count = count_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// ----------------------------------------------------------------------------
// tb_nes_pad_responder
// Directed bench for nes_pad_responder with default parameters (TURBO_DIV = 2
// when NES_PAD_TURBO_EN is defined). Inputs change on the falling clock edge;
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nes_pad_responder;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] buttons;
    logic       pad_strobe;
    logic       pad_clock;
    logic       pad_data;
    logic       latch_pulse;
    logic [3:0] shift_count;
`ifdef NES_PAD_TURBO_EN
    logic [1:0] turbo_en;
`endif

    int n_checks   = 0;
    int n_errors   = 0;
    int latch_seen = 0;
    int ls;

    always #5 clock = ~clock;

    // latch_pulse is a registered one-cycle pulse, so each one is seen at
    // exactly one rising edge.
    always @(posedge clock) begin
        if (latch_pulse === 1'b1) latch_seen++;
    end

    nes_pad_responder #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (3),
        .SHIFT_ON_RISE (1),
        .FILL_PRESSED  (1)
`ifdef NES_PAD_TURBO_EN
        , .TURBO_DIV   (2)
`endif
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef NES_PAD_TURBO_EN
        .turbo_en    (turbo_en),
`endif
        .buttons     (buttons),
        .pad_strobe  (pad_strobe),
        .pad_clock   (pad_clock),
        .pad_data    (pad_data),
        .latch_pulse (latch_pulse),
        .shift_count (shift_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_clock();
        pad_clock = 1'b1;
        cycles(20);
        pad_clock = 1'b0;
        cycles(20);
    endtask

    task automatic latch_frame(input logic [7:0] b);
        buttons    = b;
        pad_strobe = 1'b1;
        cycles(20);
        pad_strobe = 1'b0;
        cycles(20);
    endtask

    // Checks the serial stream before each pulse and after the last one.
    // After 8 shifts the fill value reads as pressed (pad_data = 0).
    task automatic read_stream(input string name, input logic [7:0] snap, input int n_pulses);
        logic exp_bit;
        int   exp_cnt;
        for (int i = 0; i <= n_pulses; i++) begin
            exp_bit = (i < 8) ? ~snap[i] : 1'b0;
            exp_cnt = (i < 8) ? i : 8;
            check($sformatf("%s_data%0d", name, i), 32'(pad_data), 32'(exp_bit));
            check($sformatf("%s_count%0d", name, i), 32'(shift_count), 32'(exp_cnt));
            if (i < n_pulses) pulse_clock();
        end
    endtask

    initial begin
        reset      = 1'b1;
        buttons    = 8'h00;
        pad_strobe = 1'b0;
        pad_clock  = 1'b0;
`ifdef NES_PAD_TURBO_EN
        turbo_en   = 2'b00;
`endif

        // ---- Reset with inputs toggling, then settle and release ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            pad_strobe = ~pad_strobe;
            pad_clock  = ~pad_clock;
        end
        pad_strobe = 1'b0;
        pad_clock  = 1'b0;
        cycles(3);
        check("rst_data", 32'(pad_data), 32'd1);
        check("rst_count", 32'(shift_count), 32'd0);
        check("rst_no_latch", 32'(latch_seen), 32'd0);
        reset = 1'b0;
        cycles(20);
        check("post_rst_data", 32'(pad_data), 32'd1);
        check("post_rst_count", 32'(shift_count), 32'd0);
        check("post_rst_no_latch", 32'(latch_seen), 32'd0);

        // ---- Basic read: A, Select, Right pressed, 10 pulses ----
        ls         = latch_seen;
        buttons    = 8'b1000_0101;
        pad_strobe = 1'b1;
        cycles(20);
        check("load_data", 32'(pad_data), 32'd0);
        check("load_count", 32'(shift_count), 32'd0);
        pad_strobe = 1'b0;
        cycles(20);
        check("latch_once", 32'(latch_seen - ls), 32'd1);
        read_stream("basic", 8'b1000_0101, 10);

        // ---- Snapshot hold: buttons change after the strobe falls ----
        latch_frame(8'h01);
        buttons = 8'hFE;
        read_stream("snap_old", 8'h01, 8);
        latch_frame(8'hFE);
        read_stream("snap_new", 8'hFE, 8);

        // ---- Glitch rejection: 2-cycle pulses ignored, 3-cycle accepted ----
        latch_frame(8'h0A);
        for (int i = 0; i < 3; i++) begin
            pad_clock = 1'b1;
            cycles(2);
            pad_clock = 1'b0;
            cycles(10);
            check($sformatf("glitch_count%0d", i), 32'(shift_count), 32'd0);
            check($sformatf("glitch_data%0d", i), 32'(pad_data), 32'd1);
        end
        pad_clock = 1'b1;
        cycles(3);
        pad_clock = 1'b0;
        cycles(20);
        check("min_pulse_count", 32'(shift_count), 32'd1);
        check("min_pulse_data", 32'(pad_data), 32'd0);

        // ---- Priority: strobe rise and shift edge accepted together ----
        latch_frame(8'h01);
        pulse_clock();
        pulse_clock();
        pulse_clock();
        check("prio_pre_count", 32'(shift_count), 32'd3);
        check("prio_pre_data", 32'(pad_data), 32'd1);
        pad_strobe = 1'b1;
        pad_clock  = 1'b1;
        cycles(5);
        check("prio_before_edge", 32'(shift_count), 32'd3);
        cycles(1);
        check("prio_count", 32'(shift_count), 32'd0);
        check("prio_data", 32'(pad_data), 32'd0);
        cycles(20);
        pad_clock  = 1'b0;
        pad_strobe = 1'b0;
        cycles(20);
        check("prio_after_latch_data", 32'(pad_data), 32'd0);

        // ---- Reset asserted mid-transfer ----
        latch_frame(8'hFF);
        pulse_clock();
        pulse_clock();
        check("mid_pre_count", 32'(shift_count), 32'd2);
        check("mid_pre_data", 32'(pad_data), 32'd0);
        reset = 1'b1;
        cycles(1);
        check("mid_rst_count", 32'(shift_count), 32'd0);
        check("mid_rst_data", 32'(pad_data), 32'd1);
        reset = 1'b0;
        cycles(10);

`ifdef NES_PAD_TURBO_EN
        // ---- Turbo A with TURBO_DIV = 2: two frames pressed, two released ----
        turbo_en = 2'b01;
        for (int k = 0; k < 8; k++) begin
            latch_frame(8'h01);
            check($sformatf("turbo_frame%0d", k), 32'(pad_data),
                  ((k % 4) < 2) ? 32'd0 : 32'd1);
        end
        turbo_en = 2'b00;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Controller-side end of the NES joypad serial link. Emulates a standard pad's 4021 parallel-in/serial-out shift register.
- Samples the console's joy_strobe and joy_clock lines and drives joy_data.
- Button state comes from the board (GPIO or host bridge). Used to loop the NES core back onto on-board buttons and to verify the console-side joypad reader.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on the strobe and clock inputs (minimum 2).
- FILTER_CYCLES, 3, consecutive identical synchronized samples needed to accept a level change on strobe or clock (1 to 15).
- SHIFT_ON_RISE, 1, 1 = shift on the accepted rising edge of pad_clock; 0 = shift on the falling edge.
- FILL_PRESSED, 1, value reported after 8 shifts: 1 = "pressed" (data driven low, matching an official pad); 0 = released (data high).

Ports:
- clock  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- buttons  input  8  live button state, 1 = pressed; bit order [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- pad_strobe  input  1  latch line from the console, asynchronous.
- pad_clock  input  1  shift clock from the console, asynchronous.
- pad_data  output  1  serial data, active-low (0 = pressed).
- latch_pulse  output  1  one-cycle pulse on the accepted falling edge of strobe (snapshot frozen).
- shift_count  output  4  number of shifts since the last latch, saturating at 8.

Behaviour:
- Reset: shift register = 8'h00, shift_count = 0, pad_data = 1, latch_pulse = 0. Filter states take the current synchronized input levels, so no edge is generated on reset release.
- Input conditioning: each input passes through SYNC_STAGES flops, then a filter counter. The filtered level changes only after FILTER_CYCLES consecutive equal samples. Edge detection runs on the filtered level. Input-to-edge latency is SYNC_STAGES + FILTER_CYCLES clocks.
- States:
  - LOAD: filtered strobe is high.
  - SHIFT: strobe is low and shift_count < 8.
  - DRAINED: strobe is low and shift_count = 8.
- LOAD:
  - Every cycle: shift register <= buttons, shift_count <= 0, pad_data = ~buttons[0] (A is visible during the strobe).
  - Clock edges are ignored.
- Strobe falling edge: the last loaded value is held, latch_pulse = 1 for one cycle, state -> SHIFT.
- SHIFT, on each accepted shift edge:
  - Register shifts right, with the FILL_PRESSED value entering bit 7.
  - shift_count increments.
  - pad_data = ~reg[0] of the new register value, registered one cycle after the edge.
  - When shift_count reaches 8, state -> DRAINED.
- DRAINED: pad_data = ~FILL_PRESSED. Further shift edges leave shift_count at 8 and pad_data unchanged.
- Strobe rising edge from any state -> LOAD; this takes priority over a shift edge accepted in the same cycle.
- pad_data is always a registered output; no combinational path from the inputs.
- reset asserted mid-transfer forces the reset values on the next clock.

Optional Feature:
- Macro: NES_PAD_TURBO_EN.
- When defined:
  - Adds input turbo_en (2 bits: [0]=A, [1]=B) and parameter TURBO_DIV (default 4).
  - An internal latch counter increments on each latch_pulse and wraps at 2*TURBO_DIV.
  - While turbo_en[n] is set and button n is pressed, the loaded bit n is forced to 0 when the counter >= TURBO_DIV. The result is alternating press/release every TURBO_DIV frames.
  - reset clears the latch counter.
- When not defined: no extra port, parameter or logic; buttons load unchanged.

Decomposition:
- Package nes_pad_pkg holds:
  - button index constants (BTN_A = 0 through BTN_RIGHT = 7);
  - PAD_BITS = 8;
  - the state encoding typedef (LOAD, SHIFT, DRAINED).
- One sub-module, nes_pad_in_filter: synchronizer, glitch filter and rise/fall pulse generator. It is instantiated twice (strobe, clock).

Test Plan:
- Reset behaviour: reset held 5 cycles with inputs toggling -> pad_data = 1, shift_count = 0, latch_pulse never asserted; no spurious edge after release.
- Basic read: buttons = 8'b1000_0101, strobe pulse then 8 clock pulses (each level held 20 cycles) -> pad_data reads 0 (A), 1, 0 (Select), 1, 1, 1, 1, 0 (Right). After the 9th and 10th pulses pad_data = 0 (FILL_PRESSED = 1); shift_count stays at 8.
- Snapshot hold: buttons change from 8'h01 to 8'hFE after the strobe falls -> the serial stream still reports 8'h01; the new value appears only after the next strobe.
- Glitch rejection: 2-cycle pulses on pad_clock with FILTER_CYCLES = 3 -> no shift, shift_count unchanged. A 3-cycle pulse causes exactly one shift.
- Priority: strobe rises in the same cycle a shift edge is accepted -> state LOAD, shift_count = 0, pad_data = ~buttons[0].
- Turbo (NES_PAD_TURBO_EN, TURBO_DIV = 2): A held, turbo_en = 2'b01, 8 frames -> A reads pressed, pressed, released, released, pressed, pressed, released, released.
